// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dmem_arbiter
// Brief   : Two-port round-robin arbiter in front of a byte-addressed data RAM
//           with alignment/range checking; one transaction in flight at a time.
// Revision: 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int N     = 32,
    parameter int BYTES = 256
) (
    input  logic         i_clk,
    input  logic         i_arst_n,
    input  logic         i_req_0,
    input  logic         i_we_0,
    input  logic [N-1:0] i_addr_0,
    input  logic [N-1:0] i_wdata_0,
    input  logic [3:0]   i_wstrb_0,
    input  logic         i_req_1,
    input  logic         i_we_1,
    input  logic [N-1:0] i_addr_1,
    input  logic [N-1:0] i_wdata_1,
    input  logic [3:0]   i_wstrb_1,
    output logic         o_gnt_0,
    output logic         o_rvalid_0,
    output logic [N-1:0] o_rdata_0,
    output logic         o_err_0,
    output logic         o_gnt_1,
    output logic         o_rvalid_1,
    output logic [N-1:0] o_rdata_1,
    output logic         o_err_1,
    output logic         o_mem_we,
    output logic         o_mem_re,
    output logic [N-1:0] o_mem_addr,
    output logic [N-1:0] o_mem_wdata,
    output logic [3:0]   o_mem_wstrb,
    input  logic [N-1:0] i_mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [N:0] c_BYTES = (N+1)'(BYTES);

    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_ptr;
    logic           r_port;
    logic           r_we;
    logic [N-1:0]   r_addr;
    logic [N-1:0]   r_wdata;
    logic [3:0]     r_wstrb;
    logic [N-1:0]   r_rdata_0;
    logic [N-1:0]   r_rdata_1;

    logic           w_sel;
    logic           w_take;
    logic           w_gnt_0;
    logic           w_gnt_1;
    logic           w_shape_ok;
    logic [1:0]     w_top;
    logic [N:0]     w_end;
    logic           w_legal;
    logic           w_mem_en;

    // Pointer only matters when both ports ask; a lone requester always wins.
    assign w_sel = (i_req_0 && i_req_1) ? r_ptr : i_req_1;

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_gnt_0     = 1'b0;
        w_gnt_1     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_req_0 || i_req_1) begin
                    w_take      = 1'b1;
                    w_gnt_0     = ~w_sel;
                    w_gnt_1     = w_sel;
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: w_state_nxt = S_RESP;
            S_RESP:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_shape_ok = 1'b0;
        w_top      = 2'd0;
        case (r_wstrb)
            4'b0001: begin w_shape_ok = 1'b1;                  w_top = 2'd0; end
            4'b0011: begin w_shape_ok = ~r_addr[0];            w_top = 2'd1; end
            4'b1111: begin w_shape_ok = (r_addr[1:0] == 2'b00); w_top = 2'd3; end
            default: ;
        endcase
    end

    // One extra bit keeps the end address from wrapping near the top of the space.
    assign w_end    = {1'b0, r_addr} + {{(N-1){1'b0}}, w_top};
    assign w_legal  = w_shape_ok && (w_end < c_BYTES);
    assign w_mem_en = (r_state == S_ACCESS) && w_legal;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_state   <= S_IDLE;
            r_ptr     <= 1'b0;
            r_port    <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_rdata_0 <= '0;
            r_rdata_1 <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take) begin
                r_ptr   <= ~w_sel;
                r_port  <= w_sel;
                r_we    <= w_sel ? i_we_1    : i_we_0;
                r_addr  <= w_sel ? i_addr_1  : i_addr_0;
                r_wdata <= w_sel ? i_wdata_1 : i_wdata_0;
                r_wstrb <= w_sel ? i_wstrb_1 : i_wstrb_0;
            end
            if (w_mem_en && !r_we) begin
                if (r_port) r_rdata_1 <= i_mem_rdata;
                else        r_rdata_0 <= i_mem_rdata;
            end
        end
    end

    // Grants are combinational, so they are also masked by the reset pin itself.
    assign o_gnt_0     = w_gnt_0 & i_arst_n;
    assign o_gnt_1     = w_gnt_1 & i_arst_n;
    assign o_rvalid_0  = (r_state == S_RESP) && !r_port;
    assign o_rvalid_1  = (r_state == S_RESP) &&  r_port;
    assign o_err_0     = o_rvalid_0 && !w_legal;
    assign o_err_1     = o_rvalid_1 && !w_legal;
    assign o_rdata_0   = r_rdata_0;
    assign o_rdata_1   = r_rdata_1;
    assign o_mem_we    = w_mem_en &  r_we;
    assign o_mem_re    = w_mem_en & ~r_we;
    assign o_mem_addr  = w_mem_en ? r_addr  : '0;
    assign o_mem_wdata = w_mem_en ? r_wdata : '0;
    assign o_mem_wstrb = w_mem_en ? r_wstrb : 4'b0000;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_arbiter
// Brief   : Directed, table-driven bench for dmem_arbiter with a byte RAM model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic              clk = 1'b0;
    logic              arst_n = 1'b0;
    logic [1:0]        req = '0;
    logic [1:0]        we = '0;
    logic [1:0][31:0]  addr = '0;
    logic [1:0][31:0]  wdata = '0;
    logic [1:0][3:0]   wstrb = '0;
    logic [1:0]        gnt;
    logic [1:0]        rvalid;
    logic [1:0]        err;
    logic [1:0][31:0]  rdata;
    logic              mem_we;
    logic              mem_re;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic [31:0]       mem_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.N(32), .BYTES(256)) dut (
        .i_clk       (clk),
        .i_arst_n    (arst_n),
        .i_req_0     (req[0]),
        .i_we_0      (we[0]),
        .i_addr_0    (addr[0]),
        .i_wdata_0   (wdata[0]),
        .i_wstrb_0   (wstrb[0]),
        .i_req_1     (req[1]),
        .i_we_1      (we[1]),
        .i_addr_1    (addr[1]),
        .i_wdata_1   (wdata[1]),
        .i_wstrb_1   (wstrb[1]),
        .o_gnt_0     (gnt[0]),
        .o_rvalid_0  (rvalid[0]),
        .o_rdata_0   (rdata[0]),
        .o_err_0     (err[0]),
        .o_gnt_1     (gnt[1]),
        .o_rvalid_1  (rvalid[1]),
        .o_rdata_1   (rdata[1]),
        .o_err_1     (err[1]),
        .o_mem_we    (mem_we),
        .o_mem_re    (mem_re),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_mem_wstrb (mem_wstrb),
        .i_mem_rdata (mem_rdata)
    );

    // Little-endian byte RAM: byte i of a word lives at addr+i.
    logic [7:0] mem [256];
    logic [7:0] ma;
    assign ma        = mem_addr[7:0];
    assign mem_rdata = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};

    always @(posedge clk) begin
        if (mem_we) begin
            if (mem_wstrb[0]) mem[ma]         <= mem_wdata[7:0];
            if (mem_wstrb[1]) mem[ma + 8'd1]  <= mem_wdata[15:8];
            if (mem_wstrb[2]) mem[ma + 8'd2]  <= mem_wdata[23:16];
            if (mem_wstrb[3]) mem[ma + 8'd3]  <= mem_wdata[31:24];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    // Called at posedge+1 with the arbiter idle; one lone request, full T..T+2 check.
    task automatic txn(input vec_t v);
        logic [1:0] pm;
        logic       legal;
        pm    = (v.port == 1) ? 2'b10 : 2'b01;
        legal = ~v.err;
        req[v.port]   = 1'b1;
        we[v.port]    = v.we;
        addr[v.port]  = v.addr;
        wdata[v.port] = v.wdata;
        wstrb[v.port] = v.strb;
        #1;
        chk("txn_gnt", 32'(gnt), 32'(pm));
        @(posedge clk); #1;
        req[v.port] = 1'b0;
        chk("txn_mem_we", 32'(mem_we), 32'(v.we & legal));
        chk("txn_mem_re", 32'(mem_re), 32'(~v.we & legal));
        chk("txn_mem_addr", mem_addr, legal ? v.addr : 32'h0);
        chk("txn_mem_wdata", mem_wdata, legal ? v.wdata : 32'h0);
        chk("txn_mem_wstrb", 32'(mem_wstrb), legal ? 32'(v.strb) : 32'h0);
        chk("txn_gnt_busy", 32'(gnt), 32'h0);
        @(posedge clk); #1;
        chk("txn_rvalid", 32'(rvalid), 32'(pm));
        chk("txn_err", 32'(err), v.err ? 32'(pm) : 32'h0);
        chk("txn_rdata", rdata[v.port], v.rdata);
        @(posedge clk); #1;
        chk("txn_rvalid_off", 32'(rvalid), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t tv[14];
        int   g1cnt;
        logic [1:0] exp_g, exp_v;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        tv[0]  = '{0, 1'b1, 32'h10,       32'hDEADBEEF, 4'b1111, 1'b0, 32'h0};
        tv[1]  = '{0, 1'b0, 32'h10,       32'h0,        4'b1111, 1'b0, 32'hDEADBEEF};
        tv[2]  = '{1, 1'b1, 32'h12,       32'h11111111, 4'b1111, 1'b1, 32'h0};
        tv[3]  = '{1, 1'b0, 32'hFF,       32'h0,        4'b0011, 1'b1, 32'h0};
        tv[4]  = '{0, 1'b1, 32'h21,       32'h000000AB, 4'b0001, 1'b0, 32'hDEADBEEF};
        tv[5]  = '{0, 1'b0, 32'h20,       32'h0,        4'b1111, 1'b0, 32'h0000AB00};
        tv[6]  = '{1, 1'b0, 32'h10,       32'h0,        4'b1111, 1'b0, 32'hDEADBEEF};
        tv[7]  = '{1, 1'b1, 32'hFE,       32'h00001234, 4'b0011, 1'b0, 32'hDEADBEEF};
        tv[8]  = '{1, 1'b0, 32'hFC,       32'h0,        4'b1111, 1'b0, 32'h12340000};
        tv[9]  = '{0, 1'b0, 32'h11,       32'h0,        4'b0011, 1'b1, 32'h0000AB00};
        tv[10] = '{0, 1'b0, 32'h20,       32'h0,        4'b0101, 1'b1, 32'h0000AB00};
        tv[11] = '{1, 1'b1, 32'hFFFFFFFC, 32'h22222222, 4'b1111, 1'b1, 32'h12340000};
        tv[12] = '{0, 1'b0, 32'h100,      32'h0,        4'b0001, 1'b1, 32'h0000AB00};
        tv[13] = '{1, 1'b0, 32'hFE,       32'h0,        4'b0011, 1'b0, 32'h00001234};

        // Reset state with both ports already requesting.
        req   = 2'b11;
        we    = 2'b00;
        addr  = {32'h20, 32'h10};
        wstrb = {4'b1111, 4'b1111};
        #3;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_rdata0", rdata[0], 32'h0);
        chk("rst_rdata1", rdata[1], 32'h0);
        chk("rst_mem", {mem_we, mem_re, mem_wstrb, 26'h0} | mem_addr | mem_wdata, 32'h0);

        // Contention straight out of reset: p0, p1, p0, p1 every three cycles.
        @(posedge clk); #1;
        arst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            #1;
            exp_g = 2'b00;
            exp_v = 2'b00;
            if (k % 3 == 0) exp_g = ((k / 3) % 2 == 1) ? 2'b10 : 2'b01;
            if (k % 3 == 2) exp_v = ((k / 3) % 2 == 1) ? 2'b10 : 2'b01;
            chk($sformatf("cont_gnt_c%0d", k), 32'(gnt), 32'(exp_g));
            chk($sformatf("cont_rvalid_c%0d", k), 32'(rvalid), 32'(exp_v));
            chk($sformatf("cont_err_c%0d", k), 32'(err), 32'h0);
            if (k == 11) req = 2'b00;
            @(posedge clk); #1;
        end

        for (int i = 0; i < 14; i++) txn(tv[i]);

        // Reset during the ACCESS cycle of a p1 read.
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h10; wstrb[1] = 4'b1111;
        #1;
        chk("rma_gnt", 32'(gnt), 32'h2);
        @(posedge clk); #1;
        req[1] = 1'b0;
        chk("rma_mem_re", 32'(mem_re), 32'h1);
        arst_n = 1'b0;
        #1;
        chk("rma_mem_re_rst", 32'(mem_re), 32'h0);
        chk("rma_mem_addr_rst", mem_addr, 32'h0);
        chk("rma_rvalid_rst", 32'(rvalid), 32'h0);
        chk("rma_rdata0_rst", rdata[0], 32'h0);
        chk("rma_rdata1_rst", rdata[1], 32'h0);
        repeat (2) begin
            @(posedge clk); #1;
            chk("rma_no_rvalid", 32'(rvalid), 32'h0);
        end
        arst_n = 1'b1;
        req[1] = 1'b1;
        #1;
        chk("rma_regnt", 32'(gnt), 32'h2);
        @(posedge clk); #1;
        req[1] = 1'b0;
        chk("rma_rvalid_t1", 32'(rvalid), 32'h0);
        @(posedge clk); #1;
        chk("rma_rvalid_t2", 32'(rvalid), 32'h2);
        chk("rma_err", 32'(err), 32'h0);
        chk("rma_rdata1", rdata[1], 32'hDEADBEEF);
        @(posedge clk); #1;

        // p1 raises req during p0's ACCESS and must be granted exactly at T+3.
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h40; wdata[0] = 32'h00000055; wstrb[0] = 4'b0001;
        #1;
        chk("held_gnt0", 32'(gnt), 32'h1);
        @(posedge clk); #1;
        req[0] = 1'b0;
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h40; wstrb[1] = 4'b0001;
        g1cnt = 0;
        for (int k = 1; k < 9; k++) begin
            if (k == 4) req[1] = 1'b0;
            #1;
            chk($sformatf("held_gnt_t%0d", k), 32'(gnt), (k == 3) ? 32'h2 : 32'h0);
            if (gnt[1]) g1cnt++;
            if (k == 5) begin
                chk("held_rvalid1", 32'(rvalid), 32'h2);
                chk("held_rdata1", rdata[1], 32'h00000055);
            end
            @(posedge clk); #1;
        end
        chk("held_gnt1_count", 32'(g1cnt), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
